music_box_state_play_recording: RTL

- Playback counterpart of the record path: reads 8-bit samples back out of SDRAM, starting at address 0, and presents one sample per 22.05 kHz tick to the audio output path.
- Active only while mainState equals PLAY_STATE_CODE.
- Raises stateComplete once the whole recording has been played, so MusicBoxStateController can return to DoNothing.
- Single 50 MHz domain. The sample rate arrives as a one-cycle strobe, not as a separate clock.

---
 rtl/music_box_state_play_recording.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/music_box_state_play_recording.sv
// Playback path: streams recorded 8-bit samples out of SDRAM, one per sample_tick.
// Optional build macro PLAYBACK_LOOP_EN: wrap to address 0 forever instead of stopping.
module music_box_state_play_recording #(
  parameter int         SAMPLE_COUNT    = 110250,
  parameter logic [4:0] PLAY_STATE_CODE = 5'd5,
  parameter logic [7:0] IDLE_SAMPLE     = 8'd128
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic [4:0]  mainState,
  output logic        stateComplete,
  output logic [7:0]  audio_sample,
  output logic        audio_sample_valid,
  output logic [31:0] debugString,
  output logic [24:0] sdram_inputAddress,
  output logic [15:0] sdram_writeData,
  input  logic [15:0] sdram_readData,
  output logic        sdram_isWriting,
  output logic        sdram_inputValid,
  input  logic        sdram_outputValid,
  input  logic        sdram_recievedCommand,
  input  logic        sdram_isBusy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [24:0] LAST_ADDR = 25'(SAMPLE_COUNT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [24:0] r_read_address;
  logic [7:0]  r_prefetch;
  logic        r_prefetch_valid;
  logic [15:0] r_underrun;
  logic [7:0]  r_audio;
  logic        r_audio_valid;
  logic        r_req_valid;
  logic        r_stale;
`ifdef PLAYBACK_LOOP_EN
  logic [15:0] r_loops;
`endif

  logic w_play;
  logic w_last;
  logic w_consume;
  logic w_underrun;
  logic w_capture;
  logic w_accept;
  logic w_issue;
  logic w_abandon;
  logic w_unused;

  assign w_play     = (mainState == PLAY_STATE_CODE);
  assign w_last     = (r_read_address == LAST_ADDR);
  assign w_consume  = sample_tick && r_prefetch_valid
                      && (r_state == S_HOLD);
  assign w_underrun = sample_tick && !r_prefetch_valid
                      && (r_state != S_HOLD)
                      && (r_state != S_DONE);
  assign w_capture  = (r_state == S_WAIT) && sdram_outputValid
                      && !r_stale;
  assign w_accept   = (r_state == S_REQ) && r_req_valid
                      && sdram_recievedCommand;
  assign w_issue    = (r_state == S_REQ) && !r_req_valid
                      && !sdram_isBusy && !r_stale;
  // A read still in flight when play is dropped must not land later
  assign w_abandon  = !w_play
                      && (((r_state == S_WAIT) && !sdram_outputValid)
                          || w_accept);
  assign w_unused   = ^sdram_readData[15:8];

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!w_play) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_REQ;
        S_REQ: begin
          if (w_accept) w_next = S_WAIT;
        end
        S_WAIT: begin
          if (w_capture) w_next = S_HOLD;
        end
        S_HOLD: begin
          if (w_consume) begin
`ifdef PLAYBACK_LOOP_EN
            w_next = S_REQ;
`else
            w_next = w_last ? S_DONE : S_REQ;
`endif
          end
        end
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      r_req_valid <= 1'b0;
    end else if (!w_play || w_accept) begin
      r_req_valid <= 1'b0;
    end else if (w_issue) begin
      r_req_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      r_stale <= 1'b0;
    end else if (w_abandon) begin
      r_stale <= 1'b1;
    end else if (sdram_outputValid) begin
      r_stale <= 1'b0;
    end
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      r_read_address   <= '0;
      r_prefetch       <= '0;
      r_prefetch_valid <= 1'b0;
      r_underrun       <= '0;
      r_audio          <= IDLE_SAMPLE;
      r_audio_valid    <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
      r_loops          <= '0;
`endif
    end else if (!w_play) begin
      r_read_address   <= '0;
      r_prefetch_valid <= 1'b0;
      r_underrun       <= '0;
      r_audio          <= IDLE_SAMPLE;
      r_audio_valid    <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
      r_loops          <= '0;
`endif
    end else begin
      r_audio_valid <= 1'b0;
      if (w_consume) begin
        r_audio          <= r_prefetch;
        r_audio_valid    <= 1'b1;
        r_prefetch_valid <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
        if (w_last) begin
          r_read_address <= '0;
          r_loops        <= r_loops + 16'd1;
        end else begin
          r_read_address <= r_read_address + 25'd1;
        end
`else
        r_read_address <= r_read_address + 25'd1;
`endif
      end else if (w_underrun && (r_underrun != 16'hFFFF)) begin
        r_underrun <= r_underrun + 16'd1;
      end
      // Last sample plays a full period, then output returns to mid-scale
      if ((r_state == S_DONE) && sample_tick) begin
        r_audio <= IDLE_SAMPLE;
      end
      if (w_capture) begin
        r_prefetch       <= sdram_readData[7:0];
        r_prefetch_valid <= 1'b1;
      end
    end
  end

  assign stateComplete      = (r_state == S_DONE);
  assign audio_sample       = r_audio;
  assign audio_sample_valid = r_audio_valid;
  assign sdram_inputAddress = r_read_address;
  assign sdram_inputValid   = r_req_valid;
  assign sdram_writeData    = 16'd0;
  assign sdram_isWriting    = 1'b0;
`ifdef PLAYBACK_LOOP_EN
  assign debugString = {r_loops, r_read_address[15:0]};
`else
  assign debugString = {r_underrun, r_read_address[15:0]};
`endif

endmodule
